// File: rtl/ofm_tile_collector.sv
// ofm_tile_collector
// Turns the tile-ordered dual-port result stream from CONV_ACC into
// raster-order OFM memory writes (addr = channel, row, column). It clips
// writes outside the valid output area, tracks frame completion and latches
// protocol errors in a sticky flag.
module ofm_tile_collector #(
   parameter int DATA_W    = 25,
   parameter int TI        = 16,
   parameter int TILES_W   = 4,
   parameter int BAND_ROWS = 5,
   parameter int BANDS     = 13,
   parameter int OFM_H     = 61,
   parameter int OFM_W     = 61,
   parameter int CH        = 8,
   parameter int ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] ofm_port0,
   input  logic [DATA_W-1:0] ofm_port1,
   input  logic              ofm_port0_v,
   input  logic              ofm_port1_v,
   output logic              wr0_en,
   output logic [ADDR_W-1:0] wr0_addr,
   output logic [DATA_W-1:0] wr0_data,
   output logic              wr1_en,
   output logic [ADDR_W-1:0] wr1_addr,
   output logic [DATA_W-1:0] wr1_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int OW_W = (TI > 1)        ? $clog2(TI)        : 1;
   localparam int R_W  = (BAND_ROWS > 1) ? $clog2(BAND_ROWS) : 1;
   localparam int TW_W = (TILES_W > 1)   ? $clog2(TILES_W)   : 1;
   localparam int B_W  = (BANDS > 1)     ? $clog2(BANDS)     : 1;
   localparam int OC_W = (CH > 1)        ? $clog2(CH)        : 1;

   localparam logic [OW_W-1:0] OW_LAST = OW_W'(TI - 1);
   localparam logic [TW_W-1:0] TW_LAST = TW_W'(TILES_W - 1);
   localparam logic [B_W-1:0]  B_LAST  = B_W'(BANDS - 1);
   localparam logic [OC_W-1:0] OC_LAST = OC_W'(CH - 1);

   logic [OW_W-1:0]   ow_q, ow_d;
   logic [R_W-1:0]    r_q, r_d;
   logic [TW_W-1:0]   tw_q, tw_d;
   logic [B_W-1:0]    band_q, band_d;
   logic [OC_W-1:0]   oc_q, oc_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              wr0_en_q, wr0_en_d;
   logic [ADDR_W-1:0] wr0_addr_q, wr0_addr_d;
   logic [DATA_W-1:0] wr0_data_q, wr0_data_d;
   logic              wr1_en_q, wr1_en_d;
   logic [ADDR_W-1:0] wr1_addr_q, wr1_addr_d;
   logic [DATA_W-1:0] wr1_data_q, wr1_data_d;

   logic [31:0] row0, col, addr0, addr1;
   logic        dual_ok, dual_bad, orphan, row_wrap;
   logic [31:0] step;

   // Raster position and address of the current beat; all math in 32 bits, unsigned.
   always_comb begin
      row0     = 32'(band_q) * BAND_ROWS + 32'(r_q);
      col      = 32'(tw_q) * TI + 32'(ow_q);
      addr0    = 32'(oc_q) * (OFM_H * OFM_W) + row0 * OFM_W + col;
      addr1    = addr0 + OFM_W;
      // A dual beat needs room for row r+1 inside the current band.
      dual_ok  = ofm_port0_v && ofm_port1_v && ((32'(r_q) + 32'd2) <= BAND_ROWS);
      dual_bad = ofm_port0_v && ofm_port1_v && !dual_ok;
      orphan   = ofm_port1_v && !ofm_port0_v;
      step     = dual_ok ? 32'd2 : 32'd1;
      row_wrap = (32'(r_q) + step) >= BAND_ROWS;
   end

   // Beat acceptance, counter advance, write generation and error tracking.
   always_comb begin
      ow_d       = ow_q;
      r_d        = r_q;
      tw_d       = tw_q;
      band_d     = band_q;
      oc_d       = oc_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      wr0_en_d   = 1'b0;
      wr0_addr_d = wr0_addr_q;
      wr0_data_d = wr0_data_q;
      wr1_en_d   = 1'b0;
      wr1_addr_d = wr1_addr_q;
      wr1_data_d = wr1_data_q;

      if (start) begin
         ow_d   = '0;
         r_d    = '0;
         tw_d   = '0;
         band_d = '0;
         oc_d   = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (orphan) begin
            err_d = 1'b1;
         end else if (ofm_port0_v) begin
            if (dual_bad) err_d = 1'b1;
            if ((row0 < OFM_H) && (col < OFM_W)) begin
               wr0_en_d   = 1'b1;
               wr0_addr_d = addr0[ADDR_W-1:0];
               wr0_data_d = ofm_port0;
            end
            if (dual_ok && ((row0 + 32'd1) < OFM_H) && (col < OFM_W)) begin
               wr1_en_d   = 1'b1;
               wr1_addr_d = addr1[ADDR_W-1:0];
               wr1_data_d = ofm_port1;
            end
            if (ow_q == OW_LAST) begin
               ow_d = '0;
               if (row_wrap) begin
                  r_d = '0;
                  if (tw_q == TW_LAST) begin
                     tw_d = '0;
                     if (band_q == B_LAST) begin
                        band_d = '0;
                        if (oc_q == OC_LAST) begin
                           oc_d   = '0;
                           busy_d = 1'b0;
                           done_d = 1'b1;
                        end else begin
                           oc_d = oc_q + 1'b1;
                        end
                     end else begin
                        band_d = band_q + 1'b1;
                     end
                  end else begin
                     tw_d = tw_q + 1'b1;
                  end
               end else begin
                  r_d = r_q + R_W'(step);
               end
            end else begin
               ow_d = ow_q + 1'b1;
            end
         end
      end else if (ofm_port0_v || ofm_port1_v) begin
         // Any beat outside a frame (including after done) is a protocol error.
         err_d = 1'b1;
      end
   end

   // State and registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ow_q       <= '0;
         r_q        <= '0;
         tw_q       <= '0;
         band_q     <= '0;
         oc_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wr0_en_q   <= 1'b0;
         wr0_addr_q <= '0;
         wr0_data_q <= '0;
         wr1_en_q   <= 1'b0;
         wr1_addr_q <= '0;
         wr1_data_q <= '0;
      end else begin
         ow_q       <= ow_d;
         r_q        <= r_d;
         tw_q       <= tw_d;
         band_q     <= band_d;
         oc_q       <= oc_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         wr0_en_q   <= wr0_en_d;
         wr0_addr_q <= wr0_addr_d;
         wr0_data_q <= wr0_data_d;
         wr1_en_q   <= wr1_en_d;
         wr1_addr_q <= wr1_addr_d;
         wr1_data_q <= wr1_data_d;
      end
   end

   assign wr0_en   = wr0_en_q;
   assign wr0_addr = wr0_addr_q;
   assign wr0_data = wr0_data_q;
   assign wr1_en   = wr1_en_q;
   assign wr1_addr = wr1_addr_q;
   assign wr1_data = wr1_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_ofm_tile_collector.sv
// Bench for ofm_tile_collector with default geometry.
module tb_ofm_tile_collector;

   localparam int DATA_W = 25, TI = 16, TILES_W = 4, BAND_ROWS = 5, BANDS = 13;
   localparam int OFM_H = 61, OFM_W = 61, CH = 8, ADDR_W = 16;
   localparam int BEATS_CH = TI * BAND_ROWS * TILES_W * BANDS;
   localparam int BEATS_FRAME = BEATS_CH * CH;

   logic              clk = 1'b0;
   logic              rst_n, start;
   logic [DATA_W-1:0] ofm_port0, ofm_port1;
   logic              ofm_port0_v, ofm_port1_v;
   logic              wr0_en, wr1_en, busy, done, err;
   logic [ADDR_W-1:0] wr0_addr, wr1_addr;
   logic [DATA_W-1:0] wr0_data, wr1_data;

   ofm_tile_collector dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .ofm_port0(ofm_port0), .ofm_port1(ofm_port1),
      .ofm_port0_v(ofm_port0_v), .ofm_port1_v(ofm_port1_v),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              en0;
      logic [ADDR_W-1:0] a0;
      logic [DATA_W-1:0] d0;
      logic              en1;
      logic [ADDR_W-1:0] a1;
      logic [DATA_W-1:0] d1;
      logic              busy;
      logic              done;
      logic              err;
      logic              chk_err;
   } exp_t;

   typedef struct {
      logic              v0, v1;
      logic [DATA_W-1:0] x0, x1;
      logic              e0;
      int                a0;
      logic              e1;
      int                a1;
      logic              err;
   } vec_t;

   exp_t  sb[$];
   int    n_chk = 0, n_pass = 0;
   int    n_wr0 = 0, n_done = 0;
   logic [ADDR_W-1:0] last_a0 = '0;
   string cur = "init";

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s/%s: got %0d expected %0d", cur, name, act, req);
   endtask

   function automatic exp_t mk(logic e0, int a0, logic [DATA_W-1:0] d0,
                               logic e1, int a1, logic [DATA_W-1:0] d1,
                               logic b, logic dn, logic er, logic ce);
      exp_t e;
      e.en0 = e0; e.a0 = ADDR_W'(a0); e.d0 = d0;
      e.en1 = e1; e.a1 = ADDR_W'(a1); e.d1 = d1;
      e.busy = b; e.done = dn; e.err = er; e.chk_err = ce;
      return e;
   endfunction

   // Expected result of the k-th single beat of a frame, derived from the beat index.
   function automatic exp_t single_exp(int k, logic [DATA_W-1:0] d, logic last, logic er);
      int ow, r, tw, band, oc, row, c;
      ow   = k % TI;
      r    = (k / TI) % BAND_ROWS;
      tw   = (k / (TI * BAND_ROWS)) % TILES_W;
      band = (k / (TI * BAND_ROWS * TILES_W)) % BANDS;
      oc   = k / BEATS_CH;
      row  = band * BAND_ROWS + r;
      c    = tw * TI + ow;
      return mk((row < OFM_H) && (c < OFM_W), oc * OFM_H * OFM_W + row * OFM_W + c, d,
                1'b0, 0, '0, !last, last, er, 1'b1);
   endfunction

   task automatic compare_front();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk("wr0_en", 32'(wr0_en), 32'(e.en0));
      if (e.en0) begin
         chk("wr0_addr", 32'(wr0_addr), 32'(e.a0));
         chk("wr0_data", 32'(wr0_data), 32'(e.d0));
      end
      chk("wr1_en", 32'(wr1_en), 32'(e.en1));
      if (e.en1) begin
         chk("wr1_addr", 32'(wr1_addr), 32'(e.a1));
         chk("wr1_data", 32'(wr1_data), 32'(e.d1));
      end
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      if (e.chk_err) chk("err", 32'(err), 32'(e.err));
      if (wr0_en) begin
         n_wr0++;
         last_a0 = wr0_addr;
      end
      if (done) n_done++;
   endtask

   task automatic beat(input logic v0, input logic v1, input logic [DATA_W-1:0] x0,
                       input logic [DATA_W-1:0] x1, input exp_t e);
      ofm_port0 = x0; ofm_port1 = x1; ofm_port0_v = v0; ofm_port1_v = v1;
      sb.push_back(e);
      @(posedge clk); #1;
      ofm_port0_v = 1'b0; ofm_port1_v = 1'b0;
      compare_front();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic do_start(input logic exp_err);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_err", 32'(err), 32'(exp_err));
   endtask

   task automatic check_all_zero();
      chk("z_wr0_en", 32'(wr0_en), 32'd0);
      chk("z_wr0_addr", 32'(wr0_addr), 32'd0);
      chk("z_wr0_data", 32'(wr0_data), 32'd0);
      chk("z_wr1_en", 32'(wr1_en), 32'd0);
      chk("z_wr1_addr", 32'(wr1_addr), 32'd0);
      chk("z_busy", 32'(busy), 32'd0);
      chk("z_done", 32'(done), 32'd0);
      chk("z_err", 32'(err), 32'd0);
   endtask

   vec_t tbl[8];

   initial begin
      logic [DATA_W-1:0] d;
      exp_t e;

      tbl[0] = '{1, 0, 25'd5,  25'd0,  1, 0, 0, 0,  0};
      tbl[1] = '{1, 0, 25'd11, 25'd0,  1, 1, 0, 0,  0};
      tbl[2] = '{1, 0, 25'd12, 25'd0,  1, 2, 0, 0,  0};
      tbl[3] = '{1, 1, 25'd7,  25'd9,  1, 3, 1, 64, 0};
      tbl[4] = '{0, 1, 25'd0,  25'd3,  0, 0, 0, 0,  1};
      tbl[5] = '{1, 0, 25'd13, 25'd0,  1, 4, 0, 0,  1};
      tbl[6] = '{0, 0, 25'd0,  25'd0,  0, 0, 0, 0,  1};
      tbl[7] = '{1, 1, 25'd20, 25'd21, 1, 5, 1, 66, 1};

      rst_n = 1'b0; start = 1'b0;
      ofm_port0 = '0; ofm_port1 = '0; ofm_port0_v = 1'b0; ofm_port1_v = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cur = "reset";
      check_all_zero();
      rst_n = 1'b1;

      // Short mixed sequence from a table
      cur = "table";
      do_start(1'b0);
      for (int i = 0; i < 8; i++) begin
         e = mk(tbl[i].e0, tbl[i].a0, tbl[i].x0, tbl[i].e1, tbl[i].a1, tbl[i].x1,
                1'b1, 1'b0, tbl[i].err, 1'b1);
         beat(tbl[i].v0, tbl[i].v1, tbl[i].x0, tbl[i].x1, e);
      end

      // Restart while busy keeps err; 81 single beats from a clean position
      cur = "restart";
      do_start(1'b1);
      for (int k = 0; k < 81; k++) begin
         d = 25'($urandom);
         beat(1'b1, 1'b0, d, '0, single_exp(k, d, 1'b0, 1'b1));
         if (k == 16) chk("beat17_addr", 32'(wr0_addr), 32'd61);
         if (k == 80) chk("beat81_addr", 32'(wr0_addr), 32'd16);
      end

      // Reset mid-frame with a beat present
      cur = "midreset";
      ofm_port0 = 25'd99; ofm_port0_v = 1'b1;
      do_reset();
      ofm_port0_v = 1'b0;
      check_all_zero();
      for (int k = 0; k < 3; k++)
         beat(1'b1, 1'b0, 25'(k + 40), '0, mk(0, 0, '0, 0, 0, '0, 0, 0, 0, 0));

      // 32 dual beats, 16 singles at r=4, then next tile
      cur = "dual";
      do_reset();
      do_start(1'b0);
      for (int j = 0; j < 32; j++) begin
         d = 25'($urandom);
         beat(1'b1, 1'b1, d, ~d,
              mk(1, (2 * (j / 16)) * OFM_W + (j % 16), d,
                 1, (2 * (j / 16) + 1) * OFM_W + (j % 16), ~d, 1, 0, 0, 1));
      end
      chk("dual_first_pair", 32'(wr1_addr - wr0_addr), 32'(OFM_W));
      for (int j = 0; j < 16; j++)
         beat(1'b1, 1'b0, 25'(j), '0, mk(1, 244 + j, 25'(j), 0, 0, '0, 1, 0, 0, 1));
      beat(1'b1, 1'b0, 25'd77, '0, mk(1, 16, 25'd77, 0, 0, '0, 1, 0, 0, 1));

      // Dual beat at last band row: err, port1 dropped, beat acts as single
      cur = "dual_r4";
      do_reset();
      do_start(1'b0);
      for (int j = 0; j < 32; j++)
         beat(1'b1, 1'b1, 25'(j), 25'(j + 100),
              mk(1, (2 * (j / 16)) * OFM_W + (j % 16), 25'(j),
                 1, (2 * (j / 16) + 1) * OFM_W + (j % 16), 25'(j + 100), 1, 0, 0, 1));
      beat(1'b1, 1'b1, 25'd7, 25'd9, mk(1, 244, 25'd7, 0, 0, '0, 1, 0, 1, 1));
      for (int j = 1; j < 16; j++)
         beat(1'b1, 1'b0, 25'(j), '0, mk(1, 244 + j, 25'(j), 0, 0, '0, 1, 0, 1, 1));
      beat(1'b1, 1'b0, 25'd55, '0, mk(1, 16, 25'd55, 0, 0, '0, 1, 0, 1, 1));
      beat(1'b0, 1'b1, '0, 25'd66, mk(0, 0, '0, 0, 0, '0, 1, 0, 1, 1));
      beat(1'b1, 1'b0, 25'd56, '0, mk(1, 17, 25'd56, 0, 0, '0, 1, 0, 1, 1));

      // Full frame of single beats
      cur = "frame";
      do_reset();
      do_start(1'b0);
      n_wr0 = 0; n_done = 0;
      for (int k = 0; k < BEATS_FRAME; k++) begin
         d = 25'($urandom);
         beat(1'b1, 1'b0, d, '0, single_exp(k, d, k == BEATS_FRAME - 1, 1'b0));
      end
      chk("frame_wr0_count", 32'(n_wr0), 32'(CH * OFM_H * OFM_W));
      chk("frame_last_addr", 32'(last_a0), 32'(CH * OFM_H * OFM_W - 1));
      chk("frame_done_count", 32'(n_done), 32'd1);
      @(posedge clk); #1;
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_err", 32'(err), 32'd0);
      beat(1'b1, 1'b0, 25'd3, '0, mk(0, 0, '0, 0, 0, '0, 0, 0, 1, 1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ofm_tile_collector.md
Name: ofm_tile_collector

Overview:
- Synthesizable output-side collector for CONV_ACC.
- Takes the tile-ordered ofm_port0/ofm_port1 result stream and converts each valid beat into a raster-order write for an external OFM memory: address = channel, row, column.
- Successor to the ad-hoc, fixed-geometry output bookkeeping in the conv benches. Tile width, tiles per row, band height, band count, output size and channel count are all parameters.
- Adds edge clipping, dual-row beats inside bands, done signalling and protocol error detection.

Parameters:
- DATA_W, 25, width of ofm ports and write data.
- TI, 16, columns per tile (beats per tile row).
- TILES_W, 4, tiles across one output row.
- BAND_ROWS, 5, rows per band.
- BANDS, 13, bands per channel.
- OFM_H, 61, valid output rows (≤ BANDS*BAND_ROWS).
- OFM_W, 61, valid output columns (≤ TI*TILES_W).
- CH, 8, output channels per frame.
- ADDR_W, 16, write address width (must hold CH*OFM_H*OFM_W-1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse: clear counters, begin frame
- ofm_port0  in  DATA_W  result for row r
- ofm_port1  in  DATA_W  result for row r+1
- ofm_port0_v  in  1  port0 valid
- ofm_port1_v  in  1  port1 valid (only legal with port0_v)
- wr0_en  out  1  write strobe, port0 result
- wr0_addr  out  ADDR_W  raster address
- wr0_data  out  DATA_W  data
- wr1_en  out  1  write strobe, port1 result
- wr1_addr  out  ADDR_W  raster address
- wr1_data  out  DATA_W  data
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame complete
- err  out  1  sticky protocol error

Behaviour:
- Reset: one clock, synchronous, active-low on rst_n sampled at the clk edge. All outputs and counters go to 0, including err. Reset mid-frame aborts the frame; no done is produced.
- Idle (busy=0): valid beats are ignored and produce no writes. Beats after done count as idle beats and set err.
- start: clears counters ow, r, tw, band and oc; sets busy=1 next cycle. start while busy restarts the frame; err is not cleared.
- Traversal order, innermost first: ow 0..TI-1, then r 0..BAND_ROWS-1, then tw 0..TILES_W-1, then band 0..BANDS-1, then oc 0..CH-1.
- Address calculation: row = band*BAND_ROWS+r; col = tw*TI+ow; addr = oc*OFM_H*OFM_W + row*OFM_W + col.
- Single beat (port0_v=1, port1_v=0): one write at (row, col). When ow wraps, r += 1.
- Dual beat (both valid), r ≤ BAND_ROWS-2: port0 writes (row, col), port1 writes (row+1, col). When ow wraps, r += 2.
- Dual beat with r = BAND_ROWS-1: set err, drop port1, treat the beat as single.
- port1_v without port0_v: set err, no write, counters hold.
- Clipping: if row ≥ OFM_H or col ≥ OFM_W, that port's write enable stays 0; counters still advance. The same rule applies independently to port1 using row+1.
- Write timing: outputs are registered, one cycle after the beat. wr*_en is high for exactly one cycle per accepted write. Address and data are held at their last value when en=0.
- Frame end: the beat that completes oc=CH-1, band=BANDS-1, tw=TILES_W-1, r wrap, ow wrap. done pulses in the same cycle as that beat's write outputs; busy drops in the same cycle.
- Arithmetic: addresses are computed unsigned, at least ADDR_W bits; parameters are checked by the bench, not in RTL.

Test Plan:
1. Defaults, start, single beat port0=5 → next cycle wr0_en=1, wr0_addr=0, wr0_data=5; wr1_en=0.
2. Defaults, 17 single beats → beat 17 writes addr 61 (row1, col0). Beat 81 (first beat of tw=1) writes addr 16.
3. Defaults, full frame of 33280 single beats (4160 per channel) → exactly 8*3721 = 29768 wr0 strobes. No writes for col ≥ 61 or rows 61..64. The last accepted address is 29767. done is a single pulse aligned with the final write output; busy then 0.
4. Defaults, dual beat data 7/9 at start → wr0 addr0 data7 and wr1 addr61 data9 in the same cycle. After 32 dual beats plus 16 single beats, the next beat writes addr 16 (tw=1).
5. Dual beat when r=4 (after 2 dual-row groups + 0 singles, forced) → err=1, only wr0 fires, r wraps to tw+1. A later port1_v-only beat → no write, counters unchanged, err stays 1.
6. rst_n low for one cycle mid-frame → all outputs 0 next cycle, busy=0, no done. Subsequent beats without start → no writes.
